button_conditioner: RTL and testbench

- Upstream conditioning stage for the board push-buttons.
- Synchronises and debounces each raw button input.
- Produces one-cycle press/release pulses plus a debounced level and a long-hold pulse.
- btn_press drives the buttons input of the LED controller, so one physical press toggles the inversion exactly once instead of once per clock while held.

---
 rtl/button_conditioner.sv | 130 +++++++++++++
 tb/tb_button_conditioner.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/button_conditioner.sv
// Push-button conditioner: per channel, a two-flop synchroniser, a debouncer
// that produces a clean level, and a small FSM that emits one-cycle press,
// release and long-hold pulses.
//
// Ports:
//   clk          system clock, all logic on posedge
//   rst          synchronous reset, active-high
//   btn_raw      asynchronous bouncy button pins, active-high
//   btn_level    debounced button state
//   btn_press    one-cycle pulse on a debounced 0->1 transition
//   btn_release  one-cycle pulse on a debounced 1->0 transition
//   btn_long     one-cycle pulse once the button has been held LONG_CYCLES
//                edges after its press pulse
module button_conditioner #(
    parameter int unsigned N_BTN           = 2,
    parameter int unsigned DEBOUNCE_CYCLES = 16,
    parameter int unsigned LONG_CYCLES     = 64
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_BTN-1:0] btn_raw,
    output logic [N_BTN-1:0] btn_level,
    output logic [N_BTN-1:0] btn_press,
    output logic [N_BTN-1:0] btn_release,
    output logic [N_BTN-1:0] btn_long
);

    localparam int unsigned DB_W   = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int unsigned HOLD_W = $clog2(LONG_CYCLES + 1);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_PRESSED = 2'd1,
        ST_LONG    = 2'd2
    } state_e;

    for (genvar g = 0; g < N_BTN; g++) begin : g_chan
        logic              s1_q;
        logic              s2_q;
        logic [DB_W-1:0]   db_cnt_q;
        logic [DB_W-1:0]   db_cnt_d;
        logic              level_q;
        logic              level_d;
        logic              rise_c;
        logic              fall_c;
        logic [HOLD_W-1:0] hold_q;
        state_e            state_q;
        logic              press_q;
        logic              release_q;
        logic              long_q;

        // Debounce: count consecutive disagreeing samples; flip on the last one.
        always_comb begin
            db_cnt_d = '0;
            level_d  = level_q;
            rise_c   = 1'b0;
            fall_c   = 1'b0;
            if (s2_q != level_q) begin
                if (db_cnt_q == DB_W'(DEBOUNCE_CYCLES - 1)) begin
                    level_d = ~level_q;
                    rise_c  = ~level_q;
                    fall_c  = level_q;
                end else begin
                    db_cnt_d = db_cnt_q + DB_W'(1);
                end
            end
        end

        // Synchroniser, debounce state and press/hold FSM with registered pulses.
        always_ff @(posedge clk) begin
            if (rst) begin
                s1_q      <= 1'b0;
                s2_q      <= 1'b0;
                db_cnt_q  <= '0;
                level_q   <= 1'b0;
                hold_q    <= '0;
                state_q   <= ST_IDLE;
                press_q   <= 1'b0;
                release_q <= 1'b0;
                long_q    <= 1'b0;
            end else begin
                s1_q      <= btn_raw[g];
                s2_q      <= s1_q;
                db_cnt_q  <= db_cnt_d;
                level_q   <= level_d;
                press_q   <= 1'b0;
                release_q <= 1'b0;
                long_q    <= 1'b0;
                case (state_q)
                    ST_IDLE: begin
                        if (rise_c) begin
                            hold_q  <= '0;
                            press_q <= 1'b1;
                            state_q <= ST_PRESSED;
                        end
                    end
                    ST_PRESSED: begin
                        // A fall on the same edge as the long threshold wins.
                        if (fall_c) begin
                            release_q <= 1'b1;
                            state_q   <= ST_IDLE;
                        end else if (hold_q == HOLD_W'(LONG_CYCLES - 1)) begin
                            hold_q  <= HOLD_W'(LONG_CYCLES);
                            long_q  <= 1'b1;
                            state_q <= ST_LONG;
                        end else begin
                            hold_q <= hold_q + HOLD_W'(1);
                        end
                    end
                    ST_LONG: begin
                        // Hold counter stays frozen here.
                        if (fall_c) begin
                            release_q <= 1'b1;
                            state_q   <= ST_IDLE;
                        end
                    end
                    default: begin
                        state_q <= ST_IDLE;
                    end
                endcase
            end
        end

        assign btn_level[g]   = level_q;
        assign btn_press[g]   = press_q;
        assign btn_release[g] = release_q;
        assign btn_long[g]    = long_q;
    end

endmodule

// File: tb/tb_button_conditioner.sv
// Bench for button_conditioner: a window-based behavioural model checked every
// cycle, plus directed literal checks at the key edges.
module tb_button_conditioner;

    localparam int N = 2;
    localparam int D = 4;
    localparam int L = 20;

    logic         clk = 1'b0;
    logic         rst;
    logic [N-1:0] btn_raw;
    logic [N-1:0] btn_level;
    logic [N-1:0] btn_press;
    logic [N-1:0] btn_release;
    logic [N-1:0] btn_long;

    int errors = 0;
    int checks = 0;
    bit chk_en = 1'b0;

    button_conditioner #(
        .N_BTN          (N),
        .DEBOUNCE_CYCLES(D),
        .LONG_CYCLES    (L)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .btn_raw    (btn_raw),
        .btn_level  (btn_level),
        .btn_press  (btn_press),
        .btn_release(btn_release),
        .btn_long   (btn_long)
    );

    always #5 clk = ~clk;

    // Model: raw delayed two edges; level flips once the last D delayed
    // samples all disagree with it; long fires L edges after press if still held.
    bit           m_s1   [N];
    bit           m_s2   [N];
    bit           hist   [N][D];
    bit           m_level[N];
    int           held   [N];
    bit           long_done[N];
    logic [N-1:0] exp_level, exp_press, exp_rel, exp_long;

    always @(posedge clk) begin
        if (rst) begin
            for (int c = 0; c < N; c++) begin
                m_s1[c]      = 1'b0;
                m_s2[c]      = 1'b0;
                m_level[c]   = 1'b0;
                held[c]      = 0;
                long_done[c] = 1'b1;
                for (int i = 0; i < D; i++) hist[c][i] = 1'b0;
            end
            exp_level = '0;
            exp_press = '0;
            exp_rel   = '0;
            exp_long  = '0;
        end else begin
            exp_press = '0;
            exp_rel   = '0;
            exp_long  = '0;
            for (int c = 0; c < N; c++) begin
                bit all_diff;
                for (int i = D - 1; i > 0; i--) hist[c][i] = hist[c][i-1];
                hist[c][0] = m_s2[c];
                all_diff = 1'b1;
                for (int i = 0; i < D; i++)
                    if (hist[c][i] == m_level[c]) all_diff = 1'b0;
                m_s2[c] = m_s1[c];
                m_s1[c] = btn_raw[c];
                if (all_diff) begin
                    m_level[c] = ~m_level[c];
                    if (m_level[c]) begin
                        exp_press[c] = 1'b1;
                        held[c]      = 0;
                        long_done[c] = 1'b0;
                    end else begin
                        exp_rel[c]   = 1'b1;
                        long_done[c] = 1'b1;
                    end
                end else if (m_level[c] && !long_done[c]) begin
                    held[c]++;
                    if (held[c] == L) begin
                        exp_long[c]  = 1'b1;
                        long_done[c] = 1'b1;
                    end
                end
                exp_level[c] = m_level[c];
            end
        end
    end

    task automatic check(input string name, input logic [N-1:0] act, input logic [N-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
        end
    endtask

    // Literal expectation applied to both the DUT and the model.
    task automatic lit(input string name, input logic [N-1:0] dut_v,
                       input logic [N-1:0] mdl_v, input logic [N-1:0] want);
        check({name, "_dut"}, dut_v, want);
        check({name, "_model"}, mdl_v, want);
    endtask

    task automatic wait_neg(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Every-cycle comparison against the model.
    always @(negedge clk) begin
        if (chk_en) begin
            check("level",   btn_level,   exp_level);
            check("press",   btn_press,   exp_press);
            check("release", btn_release, exp_rel);
            check("long",    btn_long,    exp_long);
        end
    end

    initial begin
        bit bounce[6];
        bounce = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
        rst     = 1'b1;
        btn_raw = '0;
        @(posedge clk);
        chk_en = 1'b1;
        repeat (2) @(posedge clk);

        // Reset state
        @(negedge clk);
        lit("rst_level", btn_level,   exp_level, 2'b00);
        lit("rst_press", btn_press,   exp_press, 2'b00);
        lit("rst_rel",   btn_release, exp_rel,   2'b00);
        lit("rst_long",  btn_long,    exp_long,  2'b00);
        rst = 1'b0;
        wait_neg(4);

        // Clean press on channel 0: visible 6 edges after the raw rise
        btn_raw = 2'b01;
        wait_neg(5);
        lit("t1_pre_level", btn_level, exp_level, 2'b00);
        lit("t1_pre_press", btn_press, exp_press, 2'b00);
        wait_neg(1);
        lit("t1_level", btn_level, exp_level, 2'b01);
        lit("t1_press", btn_press, exp_press, 2'b01);
        wait_neg(1);
        lit("t1_press_end", btn_press, exp_press, 2'b00);

        // Release, then a bouncy press
        btn_raw = 2'b00;
        wait_neg(6);
        lit("t2_rel", btn_release, exp_rel, 2'b01);
        wait_neg(6);
        for (int i = 0; i < 6; i++) begin
            btn_raw[0] = bounce[i];
            if (i < 5) wait_neg(1);
        end
        wait_neg(5);
        lit("t2_pre_press", btn_press, exp_press, 2'b00);
        lit("t2_pre_level", btn_level, exp_level, 2'b00);
        wait_neg(1);
        lit("t2_press", btn_press, exp_press, 2'b01);
        btn_raw = 2'b00;
        wait_neg(12);

        // Long hold on channel 1
        btn_raw = 2'b10;
        wait_neg(6);
        lit("t3_press", btn_press, exp_press, 2'b10);
        wait_neg(19);
        lit("t3_pre_long", btn_long, exp_long, 2'b00);
        wait_neg(1);
        lit("t3_long", btn_long, exp_long, 2'b10);
        wait_neg(14);
        btn_raw = 2'b00;
        wait_neg(5);
        lit("t3_pre_rel", btn_release, exp_rel, 2'b00);
        wait_neg(1);
        lit("t3_rel", btn_release, exp_rel, 2'b10);
        lit("t3_level", btn_level, exp_level, 2'b00);
        wait_neg(6);

        // Short press, then simultaneous press on both channels
        btn_raw = 2'b01;
        wait_neg(6);
        lit("t4_press", btn_press, exp_press, 2'b01);
        wait_neg(4);
        btn_raw = 2'b00;
        wait_neg(6);
        lit("t4_rel", btn_release, exp_rel, 2'b01);
        lit("t4_long", btn_long, exp_long, 2'b00);
        wait_neg(6);
        btn_raw = 2'b11;
        wait_neg(6);
        lit("t4_both_press", btn_press, exp_press, 2'b11);
        lit("t4_both_level", btn_level, exp_level, 2'b11);
        btn_raw = 2'b00;
        wait_neg(12);

        // Reset in the middle of a hold, raw kept high through deassertion
        btn_raw = 2'b01;
        wait_neg(6);
        lit("t5_press", btn_press, exp_press, 2'b01);
        wait_neg(12);
        rst = 1'b1;
        wait_neg(1);
        lit("t5_rst_level", btn_level,   exp_level, 2'b00);
        lit("t5_rst_press", btn_press,   exp_press, 2'b00);
        lit("t5_rst_rel",   btn_release, exp_rel,   2'b00);
        lit("t5_rst_long",  btn_long,    exp_long,  2'b00);
        rst = 1'b0;
        wait_neg(5);
        lit("t5_pre_press", btn_press, exp_press, 2'b00);
        wait_neg(1);
        lit("t5_repress", btn_press, exp_press, 2'b01);
        lit("t5_relevel", btn_level, exp_level, 2'b01);
        wait_neg(4);

        chk_en = 1'b0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
